regwrite_arbiter: RTL and testbench
===================================

# regwrite_arbiter

Write-side controller for the processor's 32x32 register file. It merges the in-order pipeline writeback stream and results from the long-latency multiply/divide unit onto the register file's single write port. Multiply/divide results are buffered in a small FIFO whenever the pipeline owns the port. The block also keeps a pending-destination scoreboard that the hazard unit queries to stall readers of registers not yet written. It sits between the writeback stage / muldiv unit and the register file write port.

## Interface
- DEPTH, 4, muldiv result FIFO entries; power of two, ≥2
- XLEN, 32, data width
- clk  in  1  rising-edge clock for all state in this block
- reset  in  1  synchronous, active-high
- wb_en  in  1  pipeline writeback valid this cycle; never back-pressured
- wb_rd  in  5  pipeline destination register
- wb_data  in  XLEN  pipeline writeback data
- md_issue  in  1  muldiv op issued this cycle; marks md_issue_rd pending
- md_issue_rd  in  5  destination of issued muldiv op
- md_valid  in  1  muldiv result offered
- md_ready  out  1  block accepts result; handshake = md_valid & md_ready at rising edge
- md_rd  in  5  muldiv result destination
- md_data  in  XLEN  muldiv result data
- q_rs1, q_rs2  in  5 each  hazard-unit query addresses
- q_busy1, q_busy2  out  1 each  queried register has an unwritten muldiv result (combinational)
- rf_we  out  1  register file write enable (registered)
- rf_a3  out  5  register file write address (registered)
- rf_wd3  out  XLEN  register file write data (registered)
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Port select each rising edge, priority order:
  1. wb_en=1 and wb_rd≠0: drive the pipeline write.
  2. FIFO non-empty: pop the head and drive it.
  3. Otherwise: rf_we=0; rf_a3 and rf_wd3 hold their previous values.
- wb_en=1 with wb_rd=0: pipeline write is dropped. The FIFO may pop that cycle (rule 2 applies).
- md_ready = (fifo_count < DEPTH) & ~reset. It depends only on occupancy, not on a same-cycle pop.
- Accepted result with md_rd≠0: pushed at FIFO tail.
- Accepted result with md_rd=0: discarded (not pushed). fifo_count and scoreboard are unchanged.
- Push and pop in the same edge are allowed: count is unchanged. A push cannot be popped in the edge it enters.
- FIFO order is strict FIFO. Pointers wrap modulo DEPTH. fifo_count runs 0..DEPTH.
- Scoreboard: pending[31:0], bit 0 hardwired 0.
  - Set at the edge where md_issue=1 and md_issue_rd≠0.
  - Cleared at the edge a FIFO entry for that register is popped to the register file.
  - Same-edge set and clear of one register: set wins.
- Pipeline writes never alter the scoreboard. Stalling WAW/RAW against pending registers is the hazard unit's job.
- q_busyN = pending[q_rsN]. Address 0 always returns 0.

## Timing
- Reset (synchronous, sampled high at a rising edge):
  - rf_we=0, rf_a3=0, rf_wd3=0.
  - FIFO emptied, fifo_count=0, pending=0.
  - md_ready=0 while reset is high.
- Reset mid-operation: buffered results and pending bits are discarded. No write is issued at that edge.
- Pipeline latency: wb_en sampled at edge k gives rf_we=1 during cycle k..k+1. The register file commits at the falling edge inside that cycle.
- Muldiv minimum latency: handshake at edge k, pop at edge k+1, rf_we=1 during cycle k+1..k+2. This requires wb_en=0 (or wb_rd=0) at edge k+1.
- Sustained pipeline writes starve the FIFO indefinitely. The FIFO drains one entry per non-pipeline cycle.
- Full boundary: at fifo_count=DEPTH, md_ready=0 for that cycle even if a pop occurs. md_ready returns to 1 the cycle after count drops.
- Empty boundary with no wb_en: rf_we=0. No spurious write of stale data.
- Back-to-back handshakes accepted every cycle while not full.

## Test plan
- Reset then idle → rf_we=0, rf_a3=0, rf_wd3=0, fifo_count=0, md_ready=1, q_busy1=q_busy2=0 for 3 cycles.
- wb_en=1, wb_rd=5, wb_data=0xDEADBEEF at edge k → rf_we=1, rf_a3=5, rf_wd3=0xDEADBEEF in cycle k; rf_we=0 next cycle. wb_rd=0 instead → no write.
- md_issue rd=7; 3 cycles later md result rd=7, data=0x12345678 with wb idle → q_busy(7)=1 from the issue edge; write (7, 0x12345678) appears 1 cycle after the handshake; q_busy(7)=0 after the pop edge.
- wb_en held high 6 cycles while 4 md results (rd 1..4) arrive back to back → fifo_count reaches 4 and md_ready=0; a 5th result is stalled. After wb_en drops: writes to regs 1,2,3,4 in order on consecutive cycles, then the 5th.
- Same edge: md_issue rd=9 while a FIFO entry for rd=9 pops → pending[9] stays 1.
- reset asserted with 3 entries buffered and pending bits set → next cycle: fifo_count=0, pending=0, rf_we=0, no buffered data ever written.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// Register file write-port arbiter: pipeline writeback has priority,
// muldiv results queue in a FIFO, and a scoreboard tracks pending rd.
module regwrite_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_en,
  input  logic [4:0]               wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     md_issue,
  input  logic [4:0]               md_issue_rd,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [4:0]               md_rd,
  input  logic [XLEN-1:0]          md_data,
  input  logic [4:0]               q_rs1,
  input  logic [4:0]               q_rs2,
  output logic                     q_busy1,
  output logic                     q_busy2,
  output logic                     rf_we,
  output logic [4:0]               rf_a3,
  output logic [XLEN-1:0]          rf_wd3,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] dat_q [DEPTH];
  logic [4:0]      rd_q  [DEPTH];
  logic [PW-1:0]   wp_q, rp_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     pend_q, pend_d;
  logic            we_q;
  logic [4:0]      a3_q;
  logic [XLEN-1:0] wd_q;

  logic wb_take, pop, push, full;

  assign wb_take = wb_en & (wb_rd != 5'd0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop     = ~wb_take & (cnt_q != '0);
  assign push    = md_valid & md_ready & (md_rd != 5'd0);

  assign md_ready   = ~full & ~reset;
  assign fifo_count = cnt_q;
  assign rf_we      = we_q;
  assign rf_a3      = a3_q;
  assign rf_wd3     = wd_q;
  assign q_busy1    = pend_q[q_rs1];
  assign q_busy2    = pend_q[q_rs2];

  // A new issue outranks the retiring pop of the same register.
  always_comb begin
    pend_d = pend_q;
    if (pop) pend_d[rd_q[rp_q]] = 1'b0;
    if (md_issue) pend_d[md_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dat_q[wp_q] <= md_data;
      rd_q[wp_q]  <= md_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      we_q   <= 1'b0;
      a3_q   <= '0;
      wd_q   <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      pend_q <= pend_d;
      unique case (1'b1)
        wb_take: begin
          we_q <= 1'b1;
          a3_q <= wb_rd;
          wd_q <= wb_data;
        end
        pop: begin
          we_q <= 1'b1;
          a3_q <= rd_q[rp_q];
          wd_q <= dat_q[rp_q];
        end
        default: we_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_regwrite_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            md_issue;
  logic [4:0]      md_issue_rd;
  logic            md_valid;
  logic            md_ready;
  logic [4:0]      md_rd;
  logic [XLEN-1:0] md_data;
  logic [4:0]      q_rs1, q_rs2;
  logic            q_busy1, q_busy2;
  logic            rf_we;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd3;
  logic [2:0]      fifo_count;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  regwrite_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_ready(md_ready),
    .md_rd(md_rd), .md_data(md_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2),
    .q_busy1(q_busy1), .q_busy2(q_busy2),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered results and a pending set.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_e;
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  bit          m_rdy;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_pend = '0;
      m_we = 1'b0;
      m_a3 = '0;
      m_wd = '0;
    end else begin
      m_rdy = (mq.size() < DEPTH);
      if (wb_en && wb_rd != 5'd0) begin
        m_we = 1'b1;
        m_a3 = wb_rd;
        m_wd = wb_data;
      end else if (mq.size() > 0) begin
        m_e = mq.pop_front();
        m_we = 1'b1;
        m_a3 = m_e.rd;
        m_wd = m_e.d;
        m_pend[m_e.rd] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (md_valid && m_rdy && md_rd != 5'd0)
        mq.push_back('{md_rd, md_data});
      if (md_issue && md_issue_rd != 5'd0)
        m_pend[md_issue_rd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("m_rf_we", rf_we, m_we);
      chk("m_rf_a3", rf_a3, m_a3);
      chk("m_rf_wd3", rf_wd3, m_wd);
      chk("m_count", fifo_count, mq.size());
      chk("m_md_ready", md_ready,
          32'((mq.size() < DEPTH) && !reset));
      chk("m_busy1", q_busy1, m_pend[q_rs1]);
      chk("m_busy2", q_busy2, m_pend[q_rs2]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    md_issue = 1'b0; md_issue_rd = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
    q_rs1 = 5'd0; q_rs2 = 5'd0;
    step();
    run = 1'b1;
    step();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_we", rf_we, 0);
      chk("idle_a3", rf_a3, 0);
      chk("idle_wd", rf_wd3, 0);
      chk("idle_cnt", fifo_count, 0);
      chk("idle_rdy", md_ready, 1);
      chk("idle_busy", {q_busy1, q_busy2}, 0);
    end

    // Pipeline write, then dropped write to x0
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    step();
    chk("wb_we", rf_we, 1);
    chk("wb_a3", rf_a3, 5);
    chk("wb_wd", rf_wd3, 32'hDEADBEEF);
    wb_en = 1'b0;
    step();
    chk("wb_we_off", rf_we, 0);
    chk("wb_a3_hold", rf_a3, 5);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h11111111;
    step();
    chk("x0_we", rf_we, 0);
    chk("x0_wd_hold", rf_wd3, 32'hDEADBEEF);
    wb_en = 1'b0;

    // Single muldiv op on x7
    md_issue = 1'b1; md_issue_rd = 5'd7; q_rs1 = 5'd7;
    step();
    chk("md7_busy_set", q_busy1, 1);
    md_issue = 1'b0;
    step();
    step();
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h12345678;
    step();
    md_valid = 1'b0;
    chk("md7_hs_we", rf_we, 0);
    chk("md7_hs_cnt", fifo_count, 1);
    chk("md7_still_busy", q_busy1, 1);
    step();
    chk("md7_we", rf_we, 1);
    chk("md7_a3", rf_a3, 7);
    chk("md7_wd", rf_wd3, 32'h12345678);
    chk("md7_busy_clr", q_busy1, 0);
    chk("md7_cnt", fifo_count, 0);

    // Pipeline starves FIFO until full, fifth result stalls
    wb_en = 1'b1; wb_rd = 5'd10;
    for (int i = 1; i <= 4; i++) begin
      md_valid = 1'b1; md_rd = 5'(i);
      md_data = 32'(32'hA0 + i); wb_data = 32'(32'hC0 + i);
      step();
    end
    chk("full_cnt", fifo_count, 4);
    chk("full_rdy", md_ready, 0);
    chk("full_wb_a3", rf_a3, 10);
    md_rd = 5'd5; md_data = 32'hA5;
    step();
    step();
    chk("full_cnt2", fifo_count, 4);
    wb_en = 1'b0;
    step();
    chk("drain1_a3", rf_a3, 1);
    chk("drain1_wd", rf_wd3, 32'hA1);
    chk("drain1_cnt", fifo_count, 3);
    chk("drain1_rdy", md_ready, 1);
    step();
    md_valid = 1'b0;
    chk("drain2_a3", rf_a3, 2);
    chk("drain2_cnt", fifo_count, 3);
    step();
    chk("drain3_a3", rf_a3, 3);
    step();
    chk("drain4_a3", rf_a3, 4);
    step();
    chk("drain5_a3", rf_a3, 5);
    chk("drain5_wd", rf_wd3, 32'hA5);
    step();
    chk("drained_we", rf_we, 0);
    chk("drained_cnt", fifo_count, 0);

    // Same-edge issue and pop of x9: stays pending
    md_issue = 1'b1; md_issue_rd = 5'd9; q_rs2 = 5'd9;
    step();
    md_issue = 1'b0;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
    step();
    md_valid = 1'b0;
    md_issue = 1'b1; md_issue_rd = 5'd9;
    step();
    md_issue = 1'b0;
    chk("x9_pop_a3", rf_a3, 9);
    chk("x9_busy", q_busy2, 1);

    // Reset with three buffered entries
    wb_en = 1'b1; wb_rd = 5'd12; wb_data = 32'hC12;
    for (int i = 0; i < 3; i++) begin
      md_issue = (i < 2); md_issue_rd = 5'(20 + i);
      md_valid = 1'b1; md_rd = 5'(20 + i);
      md_data = 32'(32'hB0 + i);
      step();
    end
    md_issue = 1'b0; md_valid = 1'b0;
    q_rs1 = 5'd20; q_rs2 = 5'd21;
    #1;
    chk("pre_rst_cnt", fifo_count, 3);
    chk("pre_rst_busy", {q_busy1, q_busy2}, 2'b11);
    wb_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_rdy", md_ready, 0);
    step();
    chk("rst_we", rf_we, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_busy", {q_busy1, q_busy2}, 0);
    reset = 1'b0;
    q_rs2 = 5'd9;
    #1;
    chk("rst_x9_clr", q_busy2, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_we", rf_we, 0);
    end

    @(negedge clk);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
